// File: rtl/nios_pio_poller.sv
// nios_pio_poller
//   Avalon-MM read master that polls one fixed address of a read-only PIO
//   slave every POLL_PERIOD cycles and hands each sampled word to fabric
//   logic over a valid/ready stream. Optionally suppresses repeated samples.
//
// Ports
//   clk              in   system clock, rising edge
//   reset            in   synchronous, active-high reset
//   enable           in   1 = keep polling; 0 = stop once the in-flight read completes
//   avm_address      out  constant POLL_ADDR
//   avm_read         out  read request, held until accepted
//   avm_waitrequest  in   slave stall
//   avm_readdata     in   slave data, valid READ_LATENCY cycles after acceptance
//   out_data         out  published sample
//   out_valid        out  out_data holds an unconsumed sample
//   out_ready        in   consumer accepts when out_valid=1
//   overrun          out  one-cycle pulse: a new sample replaced an unconsumed one
module nios_pio_poller #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 2,
  parameter int POLL_ADDR    = 0,
  parameter int READ_LATENCY = 1,
  parameter int POLL_PERIOD  = 1000,
  parameter int CHANGE_ONLY  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  localparam int TIMER_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_PERIOD - 1);
  localparam logic [2:0]         LAT_LOAD   = 3'(READ_LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_LAT  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]         state;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         lat_cnt;
  logic [DATA_W-1:0]  last_p1;
  logic               have_last_p1;

  logic accept_p0;
  logic capture_p0;
  logic publish_p0;

  // Decide whether a captured word goes out on the stream.
  function automatic logic should_publish(input logic [DATA_W-1:0] sample,
                                          input logic [DATA_W-1:0] last,
                                          input logic              have);
    should_publish = (CHANGE_ONLY == 0) || !have || (sample != last);
  endfunction

  assign avm_address = ADDR_W'(POLL_ADDR);

  // Stage p0: bus handshake and capture decision in the current cycle
  assign accept_p0  = (state == S_READ) && !avm_waitrequest;
  // lat_cnt is loaded with READ_LATENCY on the cycle after acceptance, so it
  // reads 1 exactly READ_LATENCY cycles after the acceptance cycle.
  assign capture_p0 = (state == S_LAT) && (lat_cnt == 3'd1);
  assign publish_p0 = capture_p0 && should_publish(avm_readdata, last_p1, have_last_p1);

  // Stage p1: registered FSM, timer, last-sample tracking and stream output
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      avm_read     <= 1'b0;
      timer        <= '0;
      lat_cnt      <= '0;
      last_p1      <= '0;
      have_last_p1 <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_READ;
            avm_read <= 1'b1;
          end
        end
        S_READ: begin
          if (accept_p0) begin
            state    <= S_LAT;
            avm_read <= 1'b0;
            lat_cnt  <= LAT_LOAD;
            // The acceptance cycle counts as 0, so the next cycle is 1.
            timer    <= TIMER_ONE;
          end
        end
        S_LAT: begin
          lat_cnt <= lat_cnt - 3'd1;
          timer   <= timer + TIMER_ONE;
          if (capture_p0) begin
            state <= enable ? S_WAIT : S_IDLE;
          end
        end
        S_WAIT: begin
          timer <= timer + TIMER_ONE;
          if (!enable) begin
            state <= S_IDLE;
          end else if (timer == TIMER_LAST) begin
            state    <= S_READ;
            avm_read <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          avm_read <= 1'b0;
        end
      endcase

      // A skipped sample equals last already, so always tracking it is safe.
      if (capture_p0) begin
        last_p1      <= avm_readdata;
        have_last_p1 <= 1'b1;
      end

      overrun <= 1'b0;
      if (publish_p0) begin
        out_data  <= avm_readdata;
        out_valid <= 1'b1;
        overrun   <= out_valid && !out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios_pio_poller.sv
// tb_nios_pio_poller
//   Bench for nios_pio_poller with POLL_PERIOD=8, READ_LATENCY=1. Two
//   instances share all inputs: dut0 publishes every sample, dut1 only
//   changed samples. A timestamp-based reference model tracks both.
module tb_nios_pio_poller;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int P  = 8;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          wr;
  logic [DW-1:0] rdata;
  logic          rdy;

  logic [AW-1:0] addr0, addr1;
  logic          read0, read1;
  logic [DW-1:0] d0, d1;
  logic          v0, v1, o0, o1;

  always #5 clk = ~clk;

  nios_pio_poller #(.DATA_W(DW), .ADDR_W(AW), .POLL_ADDR(0), .READ_LATENCY(RL),
                    .POLL_PERIOD(P), .CHANGE_ONLY(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wr), .avm_readdata(rdata),
    .out_data(d0), .out_valid(v0), .out_ready(rdy), .overrun(o0));

  nios_pio_poller #(.DATA_W(DW), .ADDR_W(AW), .POLL_ADDR(2), .READ_LATENCY(RL),
                    .POLL_PERIOD(P), .CHANGE_ONLY(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(addr1), .avm_read(read1), .avm_waitrequest(wr), .avm_readdata(rdata),
    .out_data(d1), .out_valid(v1), .out_ready(rdy), .overrun(o1));

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Reference model: absolute cycle timestamps for the next request and the
  // pending capture; per-instance stream state.
  bit            m_read;
  bit            m_active;
  int            m_next_req;
  int            m_cap;
  bit            m_valid [2];
  logic [DW-1:0] m_data  [2];
  bit            m_ovr   [2];
  logic [DW-1:0] m_last;
  bit            m_have;

  typedef struct {
    bit            en;
    bit            wr;
    logic [DW-1:0] rd;
    bit            rdy;
    bit            e_read;
    bit            e_valid;
    logic [DW-1:0] e_data;
    bit            e_ovr;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_step(input bit rst, input bit en, input bit w,
                            input logic [DW-1:0] d, input bit r, input int c);
    bit old_read, old_active, capnow, pub;
    int old_cap;
    if (rst) begin
      m_read = 0; m_active = 0; m_next_req = -1; m_cap = -1;
      m_last = '0; m_have = 0;
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = 0; m_data[k] = '0; m_ovr[k] = 0;
      end
      return;
    end
    old_read   = m_read;
    old_active = m_active;
    old_cap    = m_cap;
    capnow     = (old_cap == c);
    if (old_read) begin
      if (!w) begin
        m_read = 0; m_cap = c + RL; m_next_req = c + P;
      end
    end else if (!old_active) begin
      if (en) begin
        m_read = 1; m_active = 1;
      end
    end else if (capnow) begin
      m_cap = -1;
      if (!en) m_active = 0;
    end else if (old_cap == -1) begin
      if (!en) m_active = 0;
      else if (c + 1 == m_next_req) m_read = 1;
    end
    for (int k = 0; k < 2; k++) begin
      pub = capnow && (k == 0 || !m_have || d != m_last);
      if (pub) begin
        m_ovr[k]   = m_valid[k] && !r;
        m_data[k]  = d;
        m_valid[k] = 1;
      end else begin
        m_ovr[k] = 0;
        if (m_valid[k] && r) m_valid[k] = 0;
      end
    end
    if (capnow) begin
      m_last = d; m_have = 1;
    end
  endtask

  task automatic compare_all();
    check("avm_read0", {31'd0, read0}, {31'd0, m_read});
    check("out_valid0", {31'd0, v0}, {31'd0, m_valid[0]});
    check("out_data0", d0, m_data[0]);
    check("overrun0", {31'd0, o0}, {31'd0, m_ovr[0]});
    check("avm_read1", {31'd0, read1}, {31'd0, m_read});
    check("out_valid1", {31'd0, v1}, {31'd0, m_valid[1]});
    check("out_data1", d1, m_data[1]);
    check("overrun1", {31'd0, o1}, {31'd0, m_ovr[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(reset, enable, wr, rdata, rdy, cyc);
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; wr = 0; rdata = '0; rdy = 0;
    tick();
    tick();
    reset = 0;
    cyc = 0;
  endtask

  initial begin
    logic [DW-1:0] seq [5];
    logic [DW-1:0] pubq [$];
    int n0, cnt, t0, k;

    for (int i = 0; i < 12; i++)
      tbl[i] = '{en: 1'b1, wr: 1'b0, rd: 32'h2, rdy: 1'b1,
                 e_read: (i == 1 || i == 9), e_valid: (i == 3 || i == 11),
                 e_data: (i >= 3) ? 32'h2 : 32'h0, e_ovr: 1'b0};
    seq[0] = 32'h1; seq[1] = 32'h1; seq[2] = 32'h3; seq[3] = 32'h3; seq[4] = 32'h0;

    // Reset state and constant addresses
    do_reset();
    check("reset_avm_read", {31'd0, read0}, 32'd0);
    check("reset_out_valid", {31'd0, v0}, 32'd0);
    check("reset_out_data", d0, 32'd0);
    check("reset_overrun", {31'd0, o0}, 32'd0);
    check("avm_address0", {30'd0, addr0}, 32'd0);
    check("avm_address1", {30'd0, addr1}, 32'd2);

    // Scenario 1: free-running polls, table driven
    for (int i = 0; i < 12; i++) begin
      enable = tbl[i].en; wr = tbl[i].wr; rdata = tbl[i].rd; rdy = tbl[i].rdy;
      check("t1_read", {31'd0, read0}, {31'd0, tbl[i].e_read});
      check("t1_valid", {31'd0, v0}, {31'd0, tbl[i].e_valid});
      check("t1_data", d0, tbl[i].e_data);
      check("t1_overrun", {31'd0, o0}, {31'd0, tbl[i].e_ovr});
      tick();
    end
    while (cyc < 17) tick();
    check("t1_read_c17", {31'd0, read0}, 32'd1);
    tick(); tick();
    check("t1_valid_c19", {31'd0, v0}, 32'd1);

    // Scenario 2: waitrequest stalls cycles 1-3
    do_reset();
    enable = 1; rdata = 32'h2; rdy = 1;
    while (cyc < 14) begin
      wr = (cyc >= 1 && cyc <= 3);
      check("t2_read", {31'd0, read0}, {31'd0, ((cyc >= 1 && cyc <= 4) || cyc == 12)});
      check("t2_valid", {31'd0, v0}, {31'd0, (cyc == 6)});
      tick();
    end
    wr = 0;

    // Scenario 3: change-only publication
    do_reset();
    enable = 1; rdy = 1; n0 = 0;
    while (cyc < 41) begin
      k = (cyc < 2) ? 0 : (cyc - 2) / 8;
      if (k > 4) k = 4;
      rdata = seq[k];
      if (v1) pubq.push_back(d1);
      if (v0) n0++;
      tick();
    end
    check("t3_pub_count1", pubq.size(), 3);
    check("t3_pub_count0", n0, 5);
    if (pubq.size() == 3) begin
      check("t3_pub0", pubq[0], 32'h1);
      check("t3_pub1", pubq[1], 32'h3);
      check("t3_pub2", pubq[2], 32'h0);
    end

    // Scenario 4: overrun with a stalled consumer
    do_reset();
    enable = 1; rdy = 0; cnt = 0;
    while (cyc < 12) begin
      rdata = (cyc < 6) ? 32'h1 : 32'h2;
      if (o0) cnt++;
      if (cyc == 11) begin
        check("t4_data", d0, 32'h2);
        check("t4_valid", {31'd0, v0}, 32'd1);
      end
      tick();
    end
    check("t4_overrun_count", cnt, 1);
    rdy = 1;
    tick();
    rdy = 0;
    check("t4_drain", {31'd0, v0}, 32'd0);

    // Scenario 5: enable drops while the read is stalled
    do_reset();
    enable = 1; rdata = 32'h3; rdy = 1; cnt = 0;
    while (cyc < 30) begin
      if (cyc >= 1) enable = 0;
      wr = (cyc >= 1 && cyc <= 5);
      if (cyc == 6) check("t5_read_c6", {31'd0, read0}, 32'd1);
      if (cyc == 8) begin
        check("t5_valid", {31'd0, v0}, 32'd1);
        check("t5_data", d0, 32'h3);
      end
      if (cyc >= 7 && read0) cnt++;
      tick();
    end
    wr = 0;
    check("t5_no_more_reads", cnt, 0);

    // Scenario 6: reset while waiting on read latency
    t0 = cyc;
    enable = 1; rdata = 32'h1; rdy = 1; cnt = 0;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0; enable = 0;
    check("t6_read", {31'd0, read0}, 32'd0);
    check("t6_valid", {31'd0, v0}, 32'd0);
    check("t6_data", d0, 32'h0);
    while (cyc < t0 + 14) begin
      if (v0) cnt++;
      tick();
    end
    check("t6_no_publish", cnt, 0);

    // Randomized traffic against the model
    do_reset();
    enable = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      wr    = ($urandom_range(0, 9) < 3);
      rdata = DW'($urandom_range(0, 3));
      rdy   = $urandom_range(0, 1) != 0;
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
